tt_um_prescaled_counter: RTL and testbench

TT_UM_PRESCALED_COUNTER -- requirements
Module: tt_um_prescaled_counter

---
 rtl/tt_um_prescaled_counter.sv | 100 ++++++++++
 tb/tb_tt_um_prescaled_counter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/tt_um_prescaled_counter.sv
// Prescaled up/down counter with programmable modulus, one-shot stop and sticky wrap flag.
// All outputs come straight from registers; the prescaler gates the counter to one step per prescale+1 enabled cycles.
module tt_um_prescaled_counter #(
    parameter int WIDTH = 8,
    parameter int PRE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             oneshot,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    input  logic [PRE_W-1:0] prescale,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_ZERO = WIDTH'(0);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
    localparam logic [PRE_W-1:0] PRE_ZERO = PRE_W'(0);

    logic [WIDTH-1:0] count_r;
    logic [PRE_W-1:0] pre_cnt_r;
    logic             tc_r;
    logic             done_r;
    logic             ovf_r;

    logic             tick_s;
    logic             terminal_s;
    logic [WIDTH-1:0] count_step_s;

    // Tick qualification and the count value a tick would produce.
    // A count above max_val is treated as terminal when counting up, so out-of-range loads wrap at once.
    always_comb begin
        tick_s       = en & (pre_cnt_r == prescale) & ~done_r;
        terminal_s   = 1'b0;
        count_step_s = count_r;
        if (up_dn) begin
            if (count_r >= max_val) begin
                terminal_s   = 1'b1;
                count_step_s = oneshot ? count_r : CNT_ZERO;
            end else begin
                count_step_s = count_r + CNT_ONE;
            end
        end else begin
            if (count_r == CNT_ZERO) begin
                terminal_s   = 1'b1;
                count_step_s = oneshot ? count_r : max_val;
            end else begin
                count_step_s = count_r - CNT_ONE;
            end
        end
    end

    // State update: reset, then load, then tick, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r   <= CNT_ZERO;
            pre_cnt_r <= PRE_ZERO;
            tc_r      <= 1'b0;
            done_r    <= 1'b0;
            ovf_r     <= 1'b0;
        end else if (load) begin
            count_r   <= load_val;
            pre_cnt_r <= PRE_ZERO;
            tc_r      <= 1'b0;
            done_r    <= 1'b0;
            ovf_r     <= clr_ovf ? 1'b0 : ovf_r;
        end else begin
            tc_r <= tick_s & terminal_s;
            if (tick_s) begin
                count_r   <= count_step_s;
                pre_cnt_r <= PRE_ZERO;
                if (terminal_s & oneshot) begin
                    done_r <= 1'b1;
                end
            end else if (en & ~done_r) begin
                pre_cnt_r <= pre_cnt_r + PRE_ONE;
            end
            // A wrap in the same cycle as a clear leaves the flag set.
            if (tick_s & terminal_s & ~oneshot) begin
                ovf_r <= 1'b1;
            end else if (clr_ovf) begin
                ovf_r <= 1'b0;
            end
        end
    end

    assign count = count_r;
    assign tc    = tc_r;
    assign done  = done_r;
    assign ovf   = ovf_r;

endmodule

// File: tb/tb_tt_um_prescaled_counter.sv
// Directed bench for tt_um_prescaled_counter: linear steps, hand-computed expectations.
module tb_tt_um_prescaled_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up_dn = 1'b1;
    logic       oneshot = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic [7:0] max_val = 8'hFF;
    logic [3:0] prescale = 4'h0;
    logic       clr_ovf = 1'b0;
    logic [7:0] count;
    logic       tc;
    logic       done;
    logic       ovf;

    int n_cmp = 0;
    int n_err = 0;

    tt_um_prescaled_counter #(.WIDTH(8), .PRE_W(4)) dut (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .oneshot(oneshot),
        .load(load), .load_val(load_val), .max_val(max_val), .prescale(prescale),
        .clr_ovf(clr_ovf), .count(count), .tc(tc), .done(done), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] exp_up [5];
        logic       exp_tc [5];
        exp_up = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1};
        exp_tc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset state
        load = 1'b1; load_val = 8'hAA; en = 1'b1;
        step();
        check("rst_count", count, 8'd0);
        check("rst_tc", tc, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ovf", ovf, 1'b0);

        // Free-run up, modulus 4
        rst = 1'b0; load = 1'b0; en = 1'b1; up_dn = 1'b1; oneshot = 1'b0;
        max_val = 8'd3; prescale = 4'd0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("free_count", count, exp_up[i]);
            check("free_tc", tc, exp_tc[i]);
        end
        check("free_ovf", ovf, 1'b1);
        clr_ovf = 1'b1;
        step();
        check("clr_ovf", ovf, 1'b0);
        check("clr_count", count, 8'd2);
        clr_ovf = 1'b0;

        // Prescale by 3, with an enable gap that must freeze the prescaler
        rst = 1'b1;
        step();
        rst = 1'b0; max_val = 8'd255; prescale = 4'd2;
        step(); check("pre_c1", count, 8'd0);
        step(); check("pre_c2", count, 8'd0);
        step(); check("pre_c3", count, 8'd1);
        step(); check("pre_c4", count, 8'd1);
        en = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("pre_freeze", count, 8'd1);
        en = 1'b1;
        step(); check("pre_resume1", count, 8'd1);
        step(); check("pre_resume2", count, 8'd2);

        // One-shot down from 2
        load = 1'b1; load_val = 8'd2; oneshot = 1'b1; up_dn = 1'b0; prescale = 4'd0;
        step();
        check("os_load", count, 8'd2);
        load = 1'b0;
        step(); check("os_c1", count, 8'd1); check("os_tc1", tc, 1'b0);
        step(); check("os_c0", count, 8'd0); check("os_tc0", tc, 1'b0);
        step(); check("os_term", count, 8'd0); check("os_tc", tc, 1'b1);
        check("os_done", done, 1'b1); check("os_ovf", ovf, 1'b0);
        step(); check("os_hold", count, 8'd0); check("os_tc_end", tc, 1'b0);
        step(); step();
        check("os_hold2", count, 8'd0); check("os_done2", done, 1'b1);

        // Load priority over a pending tick
        load = 1'b1; load_val = 8'h10; oneshot = 1'b0; up_dn = 1'b1; prescale = 4'd1;
        step();
        check("ld_done_clr", done, 1'b0);
        load = 1'b0;
        step(); check("ld_pending", count, 8'h10);
        load = 1'b1; load_val = 8'h55;
        step();
        check("ld_count", count, 8'h55); check("ld_tc", tc, 1'b0); check("ld_done", done, 1'b0);
        load = 1'b0;
        step(); check("ld_pre0", count, 8'h55);
        step(); check("ld_tick", count, 8'h56);

        // Out-of-range load: up wraps at once, down decrements
        load = 1'b1; load_val = 8'd9; max_val = 8'd5; prescale = 4'd0;
        step();
        check("oor_load", count, 8'd9);
        load = 1'b0; clr_ovf = 1'b1;
        step();
        check("oor_count", count, 8'd0); check("oor_tc", tc, 1'b1); check("oor_ovf", ovf, 1'b1);
        clr_ovf = 1'b0;
        load = 1'b1; load_val = 8'd9; up_dn = 1'b0;
        step();
        load = 1'b0;
        step(); check("oor_down", count, 8'd8);

        // Reset mid-count and mid-prescale, with load also asserted
        load = 1'b1; load_val = 8'd7; up_dn = 1'b1; max_val = 8'd255; prescale = 4'd2;
        step();
        load = 1'b0;
        step(); check("mid_count", count, 8'd7);
        rst = 1'b1; load = 1'b1; load_val = 8'h33;
        step();
        check("mid_rst_count", count, 8'd0); check("mid_rst_tc", tc, 1'b0);
        check("mid_rst_done", done, 1'b0); check("mid_rst_ovf", ovf, 1'b0);
        rst = 1'b0; load = 1'b0;
        step(); check("mid_r1", count, 8'd0);
        step(); check("mid_r2", count, 8'd0);
        step(); check("mid_r3", count, 8'd1);

        // max_val = 0: every tick is terminal in both directions
        max_val = 8'd0; prescale = 4'd0;
        step(); check("m0_up_count", count, 8'd0); check("m0_up_tc", tc, 1'b1);
        up_dn = 1'b0;
        step(); check("m0_dn_count", count, 8'd0); check("m0_dn_tc", tc, 1'b1);
        check("m0_ovf", ovf, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
